// File: rtl/boot_rom_arbiter.sv
// Two-port (instruction fetch / data load) front end for the boot ROM macro.
// Arbitrates fairly between the ports, drives CSN/A, and returns Q or an error one cycle after grant.
module boot_rom_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int ROM_DEPTH  = 548,
    parameter int DATA_W     = 32
) (
    input  logic                  CLK,
    input  logic                  RSTN,

    input  logic                  instr_req_i,
    input  logic [31:0]           instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [DATA_W-1:0]     instr_rdata_o,
    output logic                  instr_err_o,

    input  logic                  data_req_i,
    input  logic                  data_we_i,
    input  logic [31:0]           data_addr_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [DATA_W-1:0]     data_rdata_o,
    output logic                  data_err_o,

    output logic                  rom_csn_o,
    output logic [ADDR_WIDTH-3:0] rom_addr_o,
    input  logic [DATA_W-1:0]     rom_rdata_i
);

    localparam int WORD_W = ADDR_WIDTH - 2;

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

    function automatic logic out_of_range(input logic [WORD_W-1:0] word);
        return ({{(32-WORD_W){1'b0}}, word} >= 32'(ROM_DEPTH));
    endfunction

    port_e              last_winner;

    logic [WORD_W-1:0]  instr_word_p0;
    logic [WORD_W-1:0]  data_word_p0;
    logic               contested_p0;
    logic               gnt_instr_p0;
    logic               gnt_data_p0;
    logic               vld_p0;
    port_e              sel_port_p0;
    logic [WORD_W-1:0]  sel_word_p0;
    logic               sel_err_p0;

    logic               vld_p1;
    port_e              resp_port_p1;
    logic               resp_err_p1;

    logic               unused_addr_bits;

    // Stage p0: combinational arbitration, classification and ROM drive
    assign instr_word_p0 = instr_addr_i[ADDR_WIDTH-1:2];
    assign data_word_p0  = data_addr_i[ADDR_WIDTH-1:2];
    assign contested_p0  = instr_req_i & data_req_i;

    // On a contest the port that lost last time wins; grants are held off during reset.
    assign gnt_instr_p0 = RSTN & instr_req_i & (~data_req_i  | (last_winner == PORT_DATA));
    assign gnt_data_p0  = RSTN & data_req_i  & (~instr_req_i | (last_winner == PORT_INSTR));
    assign vld_p0       = gnt_instr_p0 | gnt_data_p0;

    always_comb begin
        sel_port_p0 = PORT_INSTR;
        sel_word_p0 = instr_word_p0;
        sel_err_p0  = out_of_range(instr_word_p0);
        if (gnt_data_p0) begin
            sel_port_p0 = PORT_DATA;
            sel_word_p0 = data_word_p0;
            sel_err_p0  = data_we_i | out_of_range(data_word_p0);
        end
    end

    assign instr_gnt_o = gnt_instr_p0;
    assign data_gnt_o  = gnt_data_p0;

    always_comb begin
        rom_csn_o  = 1'b1;
        rom_addr_o = '0;
        if (vld_p0 && !sel_err_p0) begin
            rom_csn_o  = 1'b0;
            rom_addr_o = sel_word_p0;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            last_winner <= PORT_DATA;
        end else if (contested_p0) begin
            last_winner <= sel_port_p0;
        end
    end

    // Stage p1: response register, aligned with the ROM's Q
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            vld_p1       <= 1'b0;
            resp_port_p1 <= PORT_INSTR;
            resp_err_p1  <= 1'b0;
        end else begin
            vld_p1       <= vld_p0;
            resp_port_p1 <= sel_port_p0;
            resp_err_p1  <= vld_p0 & sel_err_p0;
        end
    end

    always_comb begin
        instr_rvalid_o = vld_p1 & (resp_port_p1 == PORT_INSTR);
        data_rvalid_o  = vld_p1 & (resp_port_p1 == PORT_DATA);
        instr_err_o    = instr_rvalid_o & resp_err_p1;
        data_err_o     = data_rvalid_o & resp_err_p1;
        instr_rdata_o  = (instr_rvalid_o && !resp_err_p1) ? rom_rdata_i : '0;
        data_rdata_o   = (data_rvalid_o && !resp_err_p1) ? rom_rdata_i : '0;
    end

    // Upper bits are decoded by the region select upstream; low bits are the byte offset.
    assign unused_addr_bits = ^{instr_addr_i[31:ADDR_WIDTH], instr_addr_i[1:0],
                                data_addr_i[31:ADDR_WIDTH], data_addr_i[1:0]};

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// Directed bench for boot_rom_arbiter with a registered ROM macro model.
module tb_boot_rom_arbiter;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [31:0] data_addr_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        rom_csn_o;
    logic [9:0]  rom_addr_o;
    logic [31:0] rom_rdata_i;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 CLK = ~CLK;

    boot_rom_arbiter dut (
        .CLK            (CLK),
        .RSTN           (RSTN),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_addr_i    (data_addr_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
        .rom_csn_o      (rom_csn_o),
        .rom_addr_o     (rom_addr_o),
        .rom_rdata_i    (rom_rdata_i)
    );

    function automatic logic [31:0] rom_word(input logic [9:0] idx);
        case (idx)
            10'd0:   return 32'h0000_0013;
            10'd31:  return 32'h0100_006F;
            10'd32:  return 32'h0100_006F;
            10'd33:  return 32'h0080_006F;
            10'd547: return 32'h0000_0030;
            default: return {6'h2A, idx, 16'hBEEF};
        endcase
    endfunction

    // ROM macro: samples address on the edge where CSN is low, Q valid the following cycle
    always @(posedge CLK) begin
        if (!rom_csn_o) rom_rdata_i <= rom_word(rom_addr_o);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic check_gnt(input string tag, input logic ig, input logic dg,
                             input logic csn, input logic [9:0] addr);
        check_val({tag, ".instr_gnt"}, instr_gnt_o, ig);
        check_val({tag, ".data_gnt"},  data_gnt_o,  dg);
        check_val({tag, ".rom_csn"},   rom_csn_o,   csn);
        check_val({tag, ".rom_addr"},  rom_addr_o,  addr);
    endtask

    task automatic check_resp(input string tag,
                              input logic iv, input logic [31:0] ir, input logic ie,
                              input logic dv, input logic [31:0] dr, input logic de);
        check_val({tag, ".instr_rvalid"}, instr_rvalid_o, iv);
        check_val({tag, ".instr_rdata"},  instr_rdata_o,  ir);
        check_val({tag, ".instr_err"},    instr_err_o,    ie);
        check_val({tag, ".data_rvalid"},  data_rvalid_o,  dv);
        check_val({tag, ".data_rdata"},   data_rdata_o,   dr);
        check_val({tag, ".data_err"},     data_err_o,     de);
    endtask

    // Drive one cycle's requests just after the edge, then wait for the sampling point.
    task automatic step(input logic ireq, input logic [31:0] ia,
                        input logic dreq, input logic dwe, input logic [31:0] da);
        @(posedge CLK);
        #1;
        instr_req_i  = ireq;
        instr_addr_i = ia;
        data_req_i   = dreq;
        data_we_i    = dwe;
        data_addr_i  = da;
        @(negedge CLK);
    endtask

    task automatic idle_step();
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RSTN         = 1'b0;
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0;
        data_req_i   = 1'b1;
        data_we_i    = 1'b0;
        data_addr_i  = 32'h7C;
        rom_rdata_i  = 32'h0;

        // Reset: requests present but nothing granted, outputs at reset values
        @(negedge CLK);
        check_gnt("rst", 1'b0, 1'b0, 1'b1, 10'd0);
        check_resp("rst", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        instr_req_i = 1'b0;
        data_req_i  = 1'b0;
        data_addr_i = 32'h0;
        #2 RSTN = 1'b1;

        // Single instruction read of word 0
        step(1'b1, 32'h000, 1'b0, 1'b0, 32'h0);
        check_gnt("rd0", 1'b1, 1'b0, 1'b0, 10'd0);
        check_resp("rd0", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        idle_step();
        check_gnt("rd0_idle", 1'b0, 1'b0, 1'b1, 10'd0);
        check_resp("rd0_rsp", 1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0, 1'b0);

        // Back-to-back instruction reads
        step(1'b1, 32'h07C, 1'b0, 1'b0, 32'h0);
        check_gnt("b2b_a", 1'b1, 1'b0, 1'b0, 10'd31);
        check_resp("b2b_a", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h080, 1'b0, 1'b0, 32'h0);
        check_gnt("b2b_b", 1'b1, 1'b0, 1'b0, 10'd32);
        check_resp("b2b_b", 1'b1, 32'h0100_006F, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h084, 1'b0, 1'b0, 32'h0);
        check_gnt("b2b_c", 1'b1, 1'b0, 1'b0, 10'd33);
        check_resp("b2b_c", 1'b1, 32'h0100_006F, 1'b0, 1'b0, 32'h0, 1'b0);
        idle_step();
        check_resp("b2b_d", 1'b1, 32'h0080_006F, 1'b0, 1'b0, 32'h0, 1'b0);

        // Continuous contention: I, D, I, D
        step(1'b1, 32'h000, 1'b1, 1'b0, 32'h07C);
        check_gnt("ctn1", 1'b1, 1'b0, 1'b0, 10'd0);
        check_resp("ctn1", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h000, 1'b1, 1'b0, 32'h07C);
        check_gnt("ctn2", 1'b0, 1'b1, 1'b0, 10'd31);
        check_resp("ctn2", 1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h000, 1'b1, 1'b0, 32'h07C);
        check_gnt("ctn3", 1'b1, 1'b0, 1'b0, 10'd0);
        check_resp("ctn3", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0100_006F, 1'b0);
        step(1'b1, 32'h000, 1'b1, 1'b0, 32'h07C);
        check_gnt("ctn4", 1'b0, 1'b1, 1'b0, 10'd31);
        check_resp("ctn4", 1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0, 1'b0);
        idle_step();
        check_resp("ctn5", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0100_006F, 1'b0);

        // Data write is an error and never selects the ROM
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h010);
        check_gnt("wr", 1'b0, 1'b1, 1'b1, 10'd0);
        idle_step();
        check_resp("wr_rsp", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1);

        // Range boundary: word 548 and 1023 error, word 547 is the last valid word
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h890);
        check_gnt("oor548", 1'b0, 1'b1, 1'b1, 10'd0);
        step(1'b1, 32'hFFC, 1'b0, 1'b0, 32'h0);
        check_gnt("oor1023", 1'b1, 1'b0, 1'b1, 10'd0);
        check_resp("oor548_rsp", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h88C);
        check_gnt("w547", 1'b0, 1'b1, 1'b0, 10'd547);
        check_resp("oor1023_rsp", 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        idle_step();
        check_resp("w547_rsp", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0030, 1'b0);

        // Contest won by instr leaves last_winner = INSTR; reset must restore DATA
        step(1'b1, 32'h000, 1'b1, 1'b0, 32'h07C);
        check_gnt("pre_rst", 1'b1, 1'b0, 1'b0, 10'd0);
        @(posedge CLK);
        #1;
        instr_req_i = 1'b0;
        data_req_i  = 1'b0;
        RSTN        = 1'b0;
        @(negedge CLK);
        check_gnt("mid_rst", 1'b0, 1'b0, 1'b1, 10'd0);
        check_resp("mid_rst", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        #2 RSTN = 1'b1;
        idle_step();
        check_resp("post_rst1", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        idle_step();
        check_resp("post_rst2", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h000, 1'b1, 1'b0, 32'h07C);
        check_gnt("post_rst_ctn", 1'b1, 1'b0, 1'b0, 10'd0);
        idle_step();
        check_resp("post_rst_rsp", 1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
